// File: rtl/scan_readback_ctrl_if.sv
// Scan readback bus: start/config inputs, scan-chain pins and the SRAM write port.
// Modport slave is the controller side; master is the host/environment side.
interface scan_readback_ctrl_if #(
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int MEMORY_DATA_WIDTH = 8
);
  logic                         BGN;
  logic [7:0]                   CHAIN_LEN;
  logic [7:0]                   FREQ_DIV;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic                         SO_IN;
  logic                         SEL;
  logic                         SCLK1;
  logic                         SCLK2;
  logic                         SIN_OUT;
  logic                         CEN;
  logic                         WEN;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] D;
  logic                         BUSY;
  logic                         DONE;

  modport master (
    output BGN, CHAIN_LEN, FREQ_DIV, ADDR_BGN, SO_IN,
    input  SEL, SCLK1, SCLK2, SIN_OUT, CEN, WEN, A, D, BUSY, DONE
  );

  modport slave (
    input  BGN, CHAIN_LEN, FREQ_DIV, ADDR_BGN, SO_IN,
    output SEL, SCLK1, SCLK2, SIN_OUT, CEN, WEN, A, D, BUSY, DONE
  );
endinterface

// File: rtl/scan_readback_ctrl.sv
// Scan-chain readback: capture, shift out CHAIN_LEN bits, pack LSB-first into SRAM words; registered outputs, DONE 2 cycles after a CHAIN_LEN=0 start.
// No backpressure (single-cycle SRAM strobe, BGN ignored while busy); define SCAN_RECIRC_EN to recirculate the chain back to its snapshot.
module scan_readback_ctrl #(
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int MEMORY_DATA_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  scan_readback_ctrl_if.slave bus
);
  localparam int AW  = MEMORY_ADDR_WIDTH;
  localparam int DW  = MEMORY_DATA_WIDTH;
  localparam int WBW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [WBW-1:0] WB_LAST = WBW'(DW - 1);

  typedef enum logic [2:0] {IDLE, CAPT, SHIFT, WRITE, FIN} state_t;

  state_t         state, state_nxt;
  logic [1:0]     phase, phase_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic           extra, extra_nxt;
  logic           sample, start;
  logic [7:0]     len_q, div_q, bit_cnt;
  logic [WBW-1:0] wbit;
  logic [DW-1:0]  pack, pack_smp;
  logic [AW-1:0]  wr_addr, a_r;
  logic [DW-1:0]  d_r;
  logic           sel_r, sclk1_r, sclk2_r, cen_r, wen_r, busy_r, done_r;
  logic           pair_end, last_bit, word_full, clocking_nxt;

  assign pair_end     = (phase == 2'd3);
  assign last_bit     = ((bit_cnt + 8'd1) == len_q);
  assign word_full    = (wbit == WB_LAST);
  assign clocking_nxt = (state_nxt == CAPT) || (state_nxt == SHIFT);

  always_comb begin
    pack_smp       = pack;
    pack_smp[wbit] = bus.SO_IN;
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    extra_nxt = extra;
    sample    = 1'b0;
    start     = 1'b0;
    // pair sequencer: ph0 SCLK1 high, ph1 gap, ph2 SCLK2 high, ph3 gap (sample point)
    if (state == CAPT || state == SHIFT) begin
      case (phase)
        2'd0, 2'd2: begin
          if (cnt == div_q) begin
            phase_nxt = phase + 2'd1;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: phase_nxt = phase + 2'd1;
      endcase
    end
    case (state)
      IDLE: begin
        if (bus.BGN) begin
          start     = 1'b1;
          phase_nxt = 2'd0;
          cnt_nxt   = 8'd0;
          extra_nxt = 1'b0;
          state_nxt = (bus.CHAIN_LEN == 8'd0) ? FIN : CAPT;
        end
      end
      CAPT, SHIFT: begin
        if (pair_end) begin
          if (extra) begin
            state_nxt = FIN;
          end else begin
            sample    = 1'b1;
            state_nxt = (word_full || last_bit) ? WRITE : SHIFT;
          end
        end
      end
      WRITE: begin
        if (bit_cnt == len_q) begin
`ifdef SCAN_RECIRC_EN
          extra_nxt = 1'b1;
          state_nxt = SHIFT;
`else
          state_nxt = FIN;
`endif
        end else begin
          state_nxt = SHIFT;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      phase <= 2'd0;
      cnt   <= 8'd0;
      extra <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      extra <= extra_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q   <= 8'd0;
      div_q   <= 8'd0;
      bit_cnt <= 8'd0;
      wbit    <= '0;
      pack    <= '0;
      wr_addr <= '0;
      a_r     <= '0;
      d_r     <= '0;
      sel_r   <= 1'b0;
      sclk1_r <= 1'b0;
      sclk2_r <= 1'b0;
      cen_r   <= 1'b1;
      wen_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (start) begin
        len_q   <= bus.CHAIN_LEN;
        div_q   <= bus.FREQ_DIV;
        wr_addr <= bus.ADDR_BGN;
        bit_cnt <= 8'd0;
        wbit    <= '0;
        pack    <= '0;
      end
      if (sample) begin
        bit_cnt <= bit_cnt + 8'd1;
        if (word_full || last_bit) begin
          // clearing pack here is what zero-pads a trailing partial word
          a_r     <= wr_addr;
          d_r     <= pack_smp;
          wr_addr <= wr_addr + AW'(1);
          pack    <= '0;
          wbit    <= '0;
        end else begin
          pack <= pack_smp;
          wbit <= wbit + WBW'(1);
        end
      end
      sel_r   <= (state_nxt == CAPT);
      sclk1_r <= clocking_nxt && (phase_nxt == 2'd0);
      sclk2_r <= clocking_nxt && (phase_nxt == 2'd2);
      cen_r   <= (state_nxt != WRITE);
      wen_r   <= (state_nxt != WRITE);
      busy_r  <= (state_nxt != IDLE);
      done_r  <= (state == FIN);
    end
  end

`ifdef SCAN_RECIRC_EN
  assign bus.SIN_OUT = (state == SHIFT) && bus.SO_IN;
`else
  assign bus.SIN_OUT = 1'b0;
`endif
  assign bus.SEL   = sel_r;
  assign bus.SCLK1 = sclk1_r;
  assign bus.SCLK2 = sclk2_r;
  assign bus.CEN   = cen_r;
  assign bus.WEN   = wen_r;
  assign bus.A     = a_r;
  assign bus.D     = d_r;
  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
endmodule

// File: tb/tb_scan_readback_ctrl.sv
// Bench for scan_readback_ctrl: a behavioural two-phase scan chain drives SO_IN, expected SRAM
// writes are queued per run from the chain contents and checked by a free-running monitor.
module tb_scan_readback_ctrl;
  localparam int AW = 9;
  localparam int DW = 8;
`ifdef SCAN_RECIRC_EN
  localparam int RECIRC = 1;
`else
  localparam int RECIRC = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  scan_readback_ctrl_if #(.MEMORY_ADDR_WIDTH(AW), .MEMORY_DATA_WIDTH(DW)) bus ();

  scan_readback_ctrl #(.MEMORY_ADDR_WIDTH(AW), .MEMORY_DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scan chain: cell 0 feeds SO_IN, SIN enters cell nlen-1; master follows while SCLK1 high, slave while SCLK2 high.
  logic [255:0] pin = '0;
  logic [255:0] mst = '0;
  logic [255:0] slv = '0;
  int           nlen = 0;

  always @(negedge CLK) begin
    if (bus.SCLK1)
      for (int i = 0; i < nlen; i++)
        mst[i] = bus.SEL ? pin[i] : ((i == nlen - 1) ? bus.SIN_OUT : slv[i+1]);
    if (bus.SCLK2) slv = mst;
    bus.SO_IN = slv[0];
  end

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] wr_e;
  int pairs = 0, dones = 0, overlaps = 0, run_div = 0, h1 = 0, h2 = 0;
  bit p2 = 1'b0;
  bit ign_width = 1'b0;

  always @(negedge CLK) begin
    if (bus.SCLK1 && bus.SCLK2) overlaps++;
    if (bus.DONE) begin
      dones++;
      check("busy_at_done", bus.BUSY, 0);
    end
    if (p2 && !bus.SCLK2) pairs++;
    p2 = bus.SCLK2;
    if (ign_width) begin
      h1 = 0;
      h2 = 0;
    end else begin
      if (bus.SCLK1) h1++;
      else if (h1 != 0) begin check("sclk1_width", h1, run_div + 1); h1 = 0; end
      if (bus.SCLK2) h2++;
      else if (h2 != 0) begin check("sclk2_width", h2, run_div + 1); h2 = 0; end
    end
    if (!bus.CEN || !bus.WEN) begin
      check("wr_strobes", {bus.CEN, bus.WEN}, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: A=%0h D=%0h, no write expected", bus.A, bus.D);
      end else begin
        wr_e = exp_q.pop_front();
        check("wr_addr", bus.A, wr_e[AW+DW-1:DW]);
        check("wr_data", bus.D, wr_e[DW-1:0]);
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {bus.SEL, bus.SCLK1, bus.SCLK2, bus.SIN_OUT,
                          bus.CEN, bus.WEN, bus.BUSY, bus.DONE}, 8'b0000_1100);
    check({tag, "_a"}, bus.A, 0);
    check({tag, "_d"}, bus.D, 0);
  endtask

  task automatic run(input int n, input int div, input int addr, input logic [255:0] p,
                     input string tag, output int cyc);
    int budget;
    logic [DW-1:0] w;
    logic [255:0] mask;
    // reference: ceil(n/8) words, bit k -> word k/8 bit k%8, zero padded, address wraps mod 2^AW
    for (int j = 0; j * 8 < n; j++) begin
      w = '0;
      for (int b = 0; b < 8; b++) if (j * 8 + b < n) w[b] = p[j*8 + b];
      exp_q.push_back({AW'((addr + j) % (1 << AW)), w});
    end
    @(negedge CLK);
    pin = p;
    nlen = n;
    run_div = div;
    pairs = 0;
    dones = 0;
    overlaps = 0;
    ign_width = 1'b0;
    h1 = 0;
    h2 = 0;
    bus.BGN = 1'b1;
    bus.CHAIN_LEN = 8'(n);
    bus.FREQ_DIV = 8'(div);
    bus.ADDR_BGN = AW'(addr);
    cyc = 0;
    budget = (n + 1) * (2 * div + 5) + 40;
    do begin
      @(negedge CLK);
      cyc++;
      bus.BGN = 1'b0;
      bus.CHAIN_LEN = 8'($urandom);
      bus.FREQ_DIV = 8'($urandom);
      bus.ADDR_BGN = AW'($urandom);
    end while (!bus.DONE && cyc < budget);
    check({tag, "_done_seen"}, bus.DONE, 1);
    @(negedge CLK);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_pairs"}, pairs, (n == 0) ? 0 : n + RECIRC);
    check({tag, "_overlap"}, overlaps, 0);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, bus.BUSY, 0);
    exp_q.delete();
`ifdef SCAN_RECIRC_EN
    if (n > 0) begin
      mask = (256'd1 << n) - 256'd1;
      check({tag, "_chain_restored"}, |((slv ^ p) & mask), 0);
    end
`else
    mask = '0;
`endif
  endtask

  initial begin
    int cyc;
    bus.BGN = 1'b0;
    bus.CHAIN_LEN = 8'd0;
    bus.FREQ_DIV = 8'd0;
    bus.ADDR_BGN = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset("rst_init");
    RST = 1'b0;

    run(14, 0, 0, 256'h21FE, "len14", cyc);
    run(8, 3, 37, rand256(), "div3", cyc);
    run(0, 2, 7, rand256(), "len0", cyc);
    check("len0_latency", cyc, 2);
    run(16, 0, 'h1FF, rand256(), "addr_wrap", cyc);

    // abort a 14-bit run partway through SHIFT, before its first write
    @(negedge CLK);
    pin = rand256();
    nlen = 14;
    run_div = 1;
    bus.BGN = 1'b1;
    bus.CHAIN_LEN = 8'd14;
    bus.FREQ_DIV = 8'd1;
    bus.ADDR_BGN = AW'(5);
    @(negedge CLK);
    bus.BGN = 1'b0;
    repeat (30) @(negedge CLK);
    check("abort_busy", bus.BUSY, 1);
    ign_width = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset("abort");
    RST = 1'b0;
    run(14, 1, 5, rand256(), "after_abort", cyc);

    for (int r = 0; r < 10; r++)
      run($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 511), rand256(),
          $sformatf("rnd%0d", r), cyc);
    run(255, 0, $urandom_range(0, 511), rand256(), "len255", cyc);
    run(1, 1, 3, rand256(), "len1", cyc);
    run(9, 2, 510, rand256(), "len9", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
